code_tracker: RTL and testbench

Post-acquisition fine-tracking controller for the FMDLL delay-line code. It starts from the 10-bit code delivered by the SAR search and then moves the code by ±1 LSB, one step at a time. Each step is driven by a majority-style vote filter on the phase-detector `COMP` result. It sits between the SAR/PD loop and the thermometer decoders, and reports lock once the code dithers around its final value.

---
 rtl/code_tracker.sv | 157 +++++++++++++++
 tb/tb_code_tracker.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_tracker.sv
// code_tracker: fine-tracking controller for the FMDLL delay-line code.
// Loads the SAR result, then steps the code by +/-1 LSB. Each step is decided
// by a vote filter on COMP, and lock is flagged once the steps keep reversing.
module code_tracker #(
  parameter int unsigned W        = 10,
  parameter int unsigned FILT     = 4,
  parameter int unsigned LOCK_CNT = 8
) (
  input  logic         clk4,
  input  logic         rst,
  input  logic         sar_done,
  input  logic [W-1:0] sar_q,
  input  logic         COMP,
  input  logic         track_en,
  output logic [W-1:0] code,
  output logic         code_valid,
  output logic         locked,
  output logic         up,
  output logic         dn,
  output logic         sat
);

  localparam int unsigned AW = $clog2(FILT) + 2;
  localparam int unsigned CW = $clog2(LOCK_CNT + 1);

  localparam logic signed [AW-1:0] ACC_POS  = AW'(FILT);
  localparam logic signed [AW-1:0] ACC_NEG  = -ACC_POS;
  localparam logic signed [AW-1:0] ACC_ONE  = AW'(1);
  localparam logic [W-1:0]         CODE_MAX = {W{1'b1}};
  localparam logic [CW-1:0]        REV_MAX  = CW'(LOCK_CNT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_TRACK = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t                r_state;
  logic [W-1:0]          r_code;
  logic                  r_code_valid;
  logic                  r_locked;
  logic                  r_up;
  logic                  r_dn;
  logic                  r_sat;
  logic signed [AW-1:0]  r_acc;
  logic [CW-1:0]         r_rev;
  logic                  r_have_dir;
  logic                  r_last_dir;

  logic signed [AW-1:0]  w_acc_nxt;
  logic                  w_step_up;
  logic                  w_step_dn;
  logic                  w_blocked;
  logic [CW-1:0]         w_rev_inc;

  // Vote update and step decision for the current COMP sample
  always_comb begin
    w_acc_nxt = COMP ? (r_acc + ACC_ONE) : (r_acc - ACC_ONE);
    w_step_up = (w_acc_nxt == ACC_POS);
    w_step_dn = (w_acc_nxt == ACC_NEG);
    w_blocked = (w_step_up && (r_code == CODE_MAX)) ||
                (w_step_dn && (r_code == '0));
    w_rev_inc = (r_rev == REV_MAX) ? r_rev : (r_rev + CW'(1));
  end

  // Tracking FSM with registered code, status and step pulses
  always_ff @(posedge clk4 or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_code       <= '0;
      r_code_valid <= 1'b0;
      r_locked     <= 1'b0;
      r_up         <= 1'b0;
      r_dn         <= 1'b0;
      r_sat        <= 1'b0;
      r_acc        <= '0;
      r_rev        <= '0;
      r_have_dir   <= 1'b0;
      r_last_dir   <= 1'b0;
    end else begin
      r_up  <= 1'b0;
      r_dn  <= 1'b0;
      r_sat <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (sar_done && track_en) begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_code       <= sar_q;
          r_code_valid <= 1'b1;
          r_acc        <= '0;
          r_rev        <= '0;
          r_have_dir   <= 1'b0;
          r_last_dir   <= 1'b0;
          r_locked     <= 1'b0;
          r_state      <= S_TRACK;
        end
        S_TRACK: begin
          if (!track_en) begin
            // The edge that leaves TRACK takes no vote
            r_acc   <= '0;
            r_state <= S_HOLD;
          end else if (w_step_up || w_step_dn) begin
            r_acc <= '0;
            if (w_blocked) begin
              // Boundary step: code and lock history are left alone
              r_sat <= 1'b1;
            end else begin
              if (w_step_up) begin
                r_code <= r_code + W'(1);
                r_up   <= 1'b1;
              end else begin
                r_code <= r_code - W'(1);
                r_dn   <= 1'b1;
              end
              r_have_dir <= 1'b1;
              r_last_dir <= w_step_up;
              if (r_have_dir) begin
                if (w_step_up != r_last_dir) begin
                  r_rev <= w_rev_inc;
                  if (w_rev_inc == REV_MAX) begin
                    r_locked <= 1'b1;
                  end
                end else begin
                  r_rev    <= '0;
                  r_locked <= 1'b0;
                end
              end
            end
          end else begin
            r_acc <= w_acc_nxt;
          end
        end
        S_HOLD: begin
          r_acc <= '0;
          if (track_en) begin
            r_state <= S_TRACK;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign code       = r_code;
  assign code_valid = r_code_valid;
  assign locked     = r_locked;
  assign up         = r_up;
  assign dn         = r_dn;
  assign sat        = r_sat;

endmodule

// File: tb/tb_code_tracker.sv
// tb_code_tracker: scoreboard bench for code_tracker. A cycle model predicts
// the outputs for each driven cycle; predictions are queued and compared
// after the clock edge, alongside directed checks from the test plan.
module tb_code_tracker;

  localparam int unsigned W        = 10;
  localparam int unsigned FILT     = 4;
  localparam int unsigned LOCK_CNT = 8;
  localparam int          CMAX     = (1 << W) - 1;

  logic         clk4;
  logic         rst;
  logic         sar_done;
  logic [W-1:0] sar_q;
  logic         COMP;
  logic         track_en;
  logic [W-1:0] code;
  logic         code_valid;
  logic         locked;
  logic         up;
  logic         dn;
  logic         sat;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  // Model state
  int m_st;
  int m_code;
  int m_acc;
  int m_rev;
  bit m_valid, m_locked, m_up, m_dn, m_sat, m_have, m_last;

  code_tracker #(.W(W), .FILT(FILT), .LOCK_CNT(LOCK_CNT)) dut (
    .clk4      (clk4),
    .rst       (rst),
    .sar_done  (sar_done),
    .sar_q     (sar_q),
    .COMP      (COMP),
    .track_en  (track_en),
    .code      (code),
    .code_valid(code_valid),
    .locked    (locked),
    .up        (up),
    .dn        (dn),
    .sat       (sat)
  );

  initial clk4 = 1'b0;
  always #5 clk4 = ~clk4;

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_pack();
    return 32'({code, code_valid, locked, up, dn, sat});
  endfunction

  function automatic logic [31:0] m_pack();
    logic [31:0] v;
    v    = 32'(m_code) << 5;
    v[4] = m_valid;
    v[3] = m_locked;
    v[2] = m_up;
    v[1] = m_dn;
    v[0] = m_sat;
    return v;
  endfunction

  task automatic model_reset();
    m_st = 0; m_code = 0; m_acc = 0; m_rev = 0;
    m_valid = 0; m_locked = 0; m_up = 0; m_dn = 0; m_sat = 0;
    m_have = 0; m_last = 0;
  endtask

  task automatic model_move(input bit d);
    m_acc = 0;
    if ((d && m_code == CMAX) || (!d && m_code == 0)) begin
      m_sat = 1;
    end else begin
      if (d) begin m_code = m_code + 1; m_up = 1; end
      else   begin m_code = m_code - 1; m_dn = 1; end
      if (m_have) begin
        if (d != m_last) begin
          if (m_rev < LOCK_CNT) m_rev = m_rev + 1;
          if (m_rev >= LOCK_CNT) m_locked = 1;
        end else begin
          m_rev = 0;
          m_locked = 0;
        end
      end
      m_have = 1;
      m_last = d;
    end
  endtask

  // States: 0 idle, 1 load, 2 track, 3 hold
  task automatic model_step(input bit sd, input bit te, input bit cmp, input int q);
    int a;
    m_up = 0; m_dn = 0; m_sat = 0;
    case (m_st)
      0: if (sd && te) m_st = 1;
      1: begin
        m_code = q; m_valid = 1; m_acc = 0; m_rev = 0;
        m_have = 0; m_last = 0; m_locked = 0; m_st = 2;
      end
      2: begin
        if (!te) begin
          m_acc = 0; m_st = 3;
        end else begin
          a = cmp ? m_acc + 1 : m_acc - 1;
          if (a >= int'(FILT))       model_move(1'b1);
          else if (a <= -int'(FILT)) model_move(1'b0);
          else                       m_acc = a;
        end
      end
      default: begin
        m_acc = 0;
        if (te) m_st = 2;
      end
    endcase
  endtask

  // Drive one cycle, queue its prediction, then compare after the edge
  task automatic cyc(input bit sd, input int q, input bit cmp, input bit te);
    logic [31:0] e;
    @(negedge clk4);
    sar_done = sd;
    sar_q    = W'(q);
    COMP     = cmp;
    track_en = te;
    model_step(sd, te, cmp, q);
    exp_q.push_back(m_pack());
    @(posedge clk4);
    #1;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("cycle", dut_pack(), e);
    end
  endtask

  task automatic burst(input bit cmp, input int n);
    repeat (n) cyc(1'b0, 0, cmp, 1'b1);
  endtask

  // Asynchronous reset between edges, checked before the next clock edge
  task automatic do_reset();
    @(negedge clk4);
    #2;
    rst      = 1'b1;
    sar_done = 1'b0;
    #1;
    chk("rst_async", dut_pack(), 32'd0);
    model_reset();
    @(negedge clk4);
    rst = 1'b0;
  endtask

  task automatic acquire(input int q);
    cyc(1'b1, q, 1'b0, 1'b1);
    chk("load_wait", 32'(code), 32'd0);
    cyc(1'b1, q, 1'b0, 1'b1);
    chk("load_code", 32'(code), 32'(q));
    chk("load_valid", 32'(code_valid), 32'd1);
  endtask

  initial begin
    rst = 1'b1; sar_done = 1'b0; sar_q = '0; COMP = 1'b0; track_en = 1'b0;
    model_reset();
    #3;
    chk("rst_init", dut_pack(), 32'd0);
    @(negedge clk4);
    rst = 1'b0;

    // Idle: sar_done needs track_en as well
    repeat (2) cyc(1'b0, 0, 1'b1, 1'b1);
    cyc(1'b1, 300, 1'b1, 1'b0);
    chk("idle_no_te", 32'(code_valid), 32'd0);

    // First step from 512
    acquire(512);
    burst(1'b1, 3);
    chk("pre_step", 32'(code), 32'd512);
    cyc(1'b0, 0, 1'b1, 1'b1);
    chk("step_code", 32'(code), 32'd513);
    chk("step_up", 32'(up), 32'd1);

    // Alternating bursts: 9th step is the 8th reversal
    for (int k = 2; k <= 9; k++) begin
      if (k == 2) begin
        cyc(1'b0, 0, 1'b0, 1'b1);
        chk("up_pulse_len", 32'(up), 32'd0);
        burst(1'b0, 3);
        chk("dn_code", 32'(code), 32'd512);
        chk("dn_pulse", 32'(dn), 32'd1);
      end else begin
        burst(k % 2 == 1, 4);
      end
      if (k == 8) chk("lock_pre", 32'(locked), 32'd0);
    end
    chk("lock_set", 32'(locked), 32'd1);
    chk("lock_code", 32'(code), 32'd513);
    burst(1'b1, 4);
    chk("lock_clr", 32'(locked), 32'd0);
    chk("same_dir_code", 32'(code), 32'd514);

    // HOLD with acc=3 freezes code and discards the partial vote
    burst(1'b1, 3);
    cyc(1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 0, i % 2 == 0, 1'b0);
    chk("hold_code", 32'(code), 32'd514);
    cyc(1'b0, 0, 1'b1, 1'b1);
    burst(1'b1, 3);
    chk("resume_pre", 32'(code), 32'd514);
    cyc(1'b0, 0, 1'b1, 1'b1);
    chk("resume_step", 32'(code), 32'd515);

    // sar_done ignored while tracking
    cyc(1'b1, 100, 1'b1, 1'b1);
    cyc(1'b1, 100, 1'b0, 1'b1);
    cyc(1'b0, 100, 1'b1, 1'b1);
    chk("sar_ignored", 32'(code), 32'd515);

    // Lock at 600, then asynchronous reset
    do_reset();
    acquire(599);
    for (int k = 1; k <= 9; k++) burst(k % 2 == 1, 4);
    chk("lock600", 32'(locked), 32'd1);
    chk("code600", 32'(code), 32'd600);
    do_reset();
    repeat (2) cyc(1'b0, 0, 1'b1, 1'b1);
    chk("post_rst_code", 32'(code), 32'd0);

    // Upper boundary
    do_reset();
    acquire(CMAX);
    burst(1'b1, 3);
    cyc(1'b0, 0, 1'b1, 1'b1);
    chk("sat_hi", 32'(sat), 32'd1);
    chk("sat_hi_up", 32'(up), 32'd0);
    chk("sat_hi_code", 32'(code), 32'(CMAX));
    cyc(1'b0, 0, 1'b0, 1'b1);
    chk("sat_hi_len", 32'(sat), 32'd0);

    // Lower boundary
    do_reset();
    acquire(0);
    burst(1'b0, 4);
    chk("sat_lo", 32'(sat), 32'd1);
    chk("sat_lo_dn", 32'(dn), 32'd0);
    chk("sat_lo_code", 32'(code), 32'd0);

    // Random COMP/track_en traffic checked against the model
    do_reset();
    acquire(700);
    for (int i = 0; i < 300; i++) begin
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, CMAX),
          $urandom_range(0, 1) == 1, $urandom_range(0, 7) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
